// File: rtl/target_motion_ctl.sv
// Frame-synchronous sprite motion sequencer: diagonal bounce, hit blink/score,
// and pseudo-random respawn. Position only moves on vs_in rising edges.
module target_motion_ctl #(
    parameter int H_RES      = 800,
    parameter int V_RES      = 600,
    parameter int SPR_W      = 48,
    parameter int SPR_H      = 64,
    parameter int STEP_X     = 2,
    parameter int STEP_Y     = 1,
    parameter int X0         = 100,
    parameter int Y0         = 100,
    parameter int HIT_FRAMES = 32
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        vs_in,
    input  logic        enable,
    input  logic        hit,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        visible,
    output logic        busy,
    output logic [7:0]  score
);

    localparam logic [12:0] XMAX    = 13'(H_RES - SPR_W);
    localparam logic [12:0] YMAX    = 13'(V_RES - SPR_H);
    localparam logic [12:0] STEP_X13 = 13'(STEP_X);
    localparam logic [12:0] STEP_Y13 = 13'(STEP_Y);
    localparam logic [7:0]  HIT_N   = 8'(HIT_FRAMES);

    typedef enum logic [1:0] {IDLE, MOVE, HIT, RESPAWN} state_t;

    state_t      state, state_n;
    logic        vs_q;
    logic [15:0] lfsr;
    logic        dir_x, dir_y, dir_x_n, dir_y_n;
    logic [7:0]  blink_cnt, blink_n, score_n;
    logic [11:0] xpos_n, ypos_n;
    logic [12:0] sx, sy;
    logic        frame_tick;

    // Returns {new_dir, new_pos}; dir 1 = right/down. Clamps at the edges and reverses.
    function automatic logic [12:0] step_axis(input logic [11:0] pos, input logic fwd,
                                              input logic [12:0] stp, input logic [12:0] lim);
        logic [12:0] p;
        p = {1'b0, pos};
        if (fwd) begin
            if (p + stp >= lim) return {1'b0, lim[11:0]};
            return {1'b1, 12'(p + stp)};
        end
        if (p <= stp) return {1'b1, 12'd0};
        return {1'b0, 12'(p - stp)};
    endfunction

    // Folding a 10-bit value into 0..lim works because lim is at least 512.
    function automatic logic [11:0] fold(input logic [9:0] r, input logic [12:0] lim);
        logic [12:0] rr;
        rr = {3'b000, r};
        if (rr > lim) return 12'(rr - lim - 13'd1);
        return {2'b00, r};
    endfunction

    assign frame_tick = vs_in & ~vs_q;
    assign busy       = (state == HIT) || (state == RESPAWN);
    assign visible    = ~((state == HIT) & blink_cnt[2]);

    always_comb begin
        state_n = state;
        xpos_n  = xpos;
        ypos_n  = ypos;
        dir_x_n = dir_x;
        dir_y_n = dir_y;
        blink_n = blink_cnt;
        score_n = score;
        sx      = step_axis(xpos, dir_x, STEP_X13, XMAX);
        sy      = step_axis(ypos, dir_y, STEP_Y13, YMAX);
        case (state)
            IDLE: if (enable) state_n = MOVE;
            MOVE: begin
                if (hit) begin
                    state_n = HIT;
                    blink_n = 8'd0;
                    if (score != 8'hFF) score_n = score + 8'd1;
                end else if (!enable) begin
                    state_n = IDLE;
                end else if (frame_tick) begin
                    {dir_x_n, xpos_n} = sx;
                    {dir_y_n, ypos_n} = sy;
                end
            end
            HIT: if (frame_tick) begin
                blink_n = blink_cnt + 8'd1;
                if (blink_n == HIT_N) state_n = RESPAWN;
            end
            RESPAWN: begin
                xpos_n  = fold(lfsr[9:0], XMAX);
                ypos_n  = fold(lfsr[15:6], YMAX);
                dir_x_n = lfsr[0];
                dir_y_n = lfsr[1];
                blink_n = 8'd0;
                state_n = enable ? MOVE : IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state     <= IDLE;
            vs_q      <= 1'b1;
            lfsr      <= 16'hACE1;
            xpos      <= 12'(X0);
            ypos      <= 12'(Y0);
            dir_x     <= 1'b1;
            dir_y     <= 1'b1;
            blink_cnt <= 8'd0;
            score     <= 8'd0;
        end else begin
            state     <= state_n;
            vs_q      <= vs_in;
            lfsr      <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            xpos      <= xpos_n;
            ypos      <= ypos_n;
            dir_x     <= dir_x_n;
            dir_y     <= dir_y_n;
            blink_cnt <= blink_n;
            score     <= score_n;
        end
    end

endmodule
